onchip_memory_arbiter: RTL and testbench

//  Shares the single-port 256x16 on-chip RAM between two Avalon-MM requesters (m0, m1).

---
 rtl/onchip_memory_arbiter_pkg.sv | 28 ++
 rtl/onchip_memory_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/onchip_memory_arbiter.sv | 153 +++++++++++++++
 tb/tb_onchip_memory_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared definitions for the two-requester on-chip RAM arbiter.
//   ADDR_W/DATA_W/BE_W : geometry of the 256x16 single-port RAM
//   RD_LATENCY         : cycles from read accept to readdatavalid
//   rd_tag_t           : per-read bookkeeping carried down the return pipeline
//   M0/M1              : requester ids
package onchip_mem_arb_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int BE_W       = DATA_W / 8;
    localparam int RD_LATENCY = 2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    // Reads always present every byte lane to the RAM; only writes honour
    // the requester's byteenable.
    function automatic logic [BE_W-1:0] lane_mask(input logic is_write,
                                                  input logic [BE_W-1:0] be);
        return is_write ? be : {BE_W{1'b1}};
    endfunction

endpackage

// File: rtl/onchip_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock, asynchronous active-low reset (priority returns to M0)
//   req[1:0]     : request vector, bit N = requester N
//   accept       : arbitration enable; low forces no grant and freezes priority
//   gnt[1:0]     : one-hot grant, combinational in the request cycle
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    import onchip_mem_arb_pkg::*;

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt = 2'b00;
        if (accept) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio_q == M1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end

        // Whoever was just served drops to the back of the line, so two
        // contending requesters strictly alternate.
        prio_d = prio_q;
        if (gnt != 2'b00) begin
            prio_d = gnt[1] ? M0 : M1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= M0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port 256x16 RAM between two Avalon-MM requesters.
// One access per clock, round-robin under contention, fixed read latency 2.
//   clk, reset_n           : clock, asynchronous active-low reset
//   mN_address/byteenable/read/write/writedata : requester N command (N = 0,1)
//   mN_waitrequest         : high when requester N is not accepted this cycle
//   mN_readdata            : registered read data, held between responses
//   mN_readdatavalid       : one-cycle pulse qualifying mN_readdata
//   mem_*                  : RAM s1 port; commands are combinational from the
//                            granted requester, mem_readdata is the RAM q output
module onchip_memory_arbiter #(
    parameter int ADDR_W = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W = onchip_mem_arb_pkg::DATA_W,
    parameter int BE_W   = onchip_mem_arb_pkg::BE_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    import onchip_mem_arb_pkg::*;

    // Tag stage that lines up with mem_readdata, and the stage that drives
    // readdatavalid one cycle later.
    localparam int CAP_STG = RD_LATENCY - 2;
    localparam int OUT_STG = RD_LATENCY - 1;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              granted;
    logic              sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic              sel_write;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_accept;

    rd_tag_t           tag_q [RD_LATENCY];
    rd_tag_t           tag_d [RD_LATENCY];
    logic [DATA_W-1:0] m0_readdata_q;
    logic [DATA_W-1:0] m0_readdata_d;
    logic [DATA_W-1:0] m1_readdata_q;
    logic [DATA_W-1:0] m1_readdata_d;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    // Holding accept low during reset keeps both waitrequests high and the
    // RAM deselected even though the requesters may still be asserting.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .accept  (reset_n),
        .gnt     (gnt)
    );

    always_comb begin
        granted = |gnt;
        sel_id  = gnt[1] ? M1 : M0;

        if (sel_id == M1) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_write = m1_write;
            sel_wdata = m1_writedata;
        end else begin
            sel_addr  = m0_address;
            sel_be    = m0_byteenable;
            sel_write = m0_write;
            sel_wdata = m0_writedata;
        end

        // A requester asserting read and write together is treated as a write.
        rd_accept = granted & ~sel_write;

        mem_chipselect  = granted;
        mem_write       = granted & sel_write;
        mem_debugaccess = granted & sel_write;
        mem_address     = sel_addr;
        mem_byteenable  = lane_mask(sel_write, sel_be);
        mem_writedata   = sel_wdata;
        mem_clken       = 1'b1;

        m0_waitrequest  = ~gnt[0];
        m1_waitrequest  = ~gnt[1];
    end

    always_comb begin
        tag_d[0].valid = rd_accept;
        tag_d[0].id    = sel_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // mem_readdata is only meaningful in the cycle its tag reaches
        // CAP_STG; route it to the owner and hold otherwise.
        m0_readdata_d = m0_readdata_q;
        m1_readdata_d = m1_readdata_q;
        if (tag_q[CAP_STG].valid) begin
            if (tag_q[CAP_STG].id == M1) begin
                m1_readdata_d = mem_readdata;
            end else begin
                m0_readdata_d = mem_readdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            m0_readdata_q <= '0;
            m1_readdata_q <= '0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            m0_readdata_q <= m0_readdata_d;
            m1_readdata_q <= m1_readdata_d;
        end
    end

    assign m0_readdata      = m0_readdata_q;
    assign m1_readdata      = m1_readdata_q;
    assign m0_readdatavalid = tag_q[OUT_STG].valid && (tag_q[OUT_STG].id == M0);
    assign m1_readdatavalid = tag_q[OUT_STG].valid && (tag_q[OUT_STG].id == M1);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic [7:0]  m0_address = '0, m1_address = '0;
    logic [1:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [15:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [7:0]  mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata;

    always #5 clk = ~clk;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_debugaccess  (mem_debugaccess),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Single-port RAM with registered q (one cycle read latency).
    logic [15:0] ram [256] = '{default: 16'h0000};
    logic [15:0] ram_q = 16'h0000;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write && mem_debugaccess) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end
            ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    // Reference model: a shadow memory, an alternating-priority token and a
    // queue of expected responses stamped with the cycle they must appear in.
    typedef struct {
        int          m;
        logic [15:0] data;
        int          due;
    } rsp_t;

    rsp_t        rq[$];
    logic [15:0] ref_mem [256];
    int          prio;
    int          cyc;
    logic        exp_g0, exp_g1, exp_v0, exp_v1;
    logic [15:0] exp_d0, exp_d1;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        rq.delete();
        prio   = 0;
        exp_d0 = 16'h0000;
        exp_d1 = 16'h0000;
    endtask

    task automatic model_eval();
        logic r0, r1;
        r0 = reset_n && (m0_read || m0_write);
        r1 = reset_n && (m1_read || m1_write);
        exp_g0 = r0 && (!r1 || prio == 0);
        exp_g1 = r1 && (!r0 || prio == 1);
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
        if (reset_n && rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].m == 0) begin
                exp_v0 = 1'b1;
                exp_d0 = rq[0].data;
            end else begin
                exp_v1 = 1'b1;
                exp_d1 = rq[0].data;
            end
        end
    endtask

    task automatic model_commit();
        int          m;
        logic        w;
        logic [7:0]  a;
        logic [1:0]  be;
        logic [15:0] d;
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (exp_g0 || exp_g1) begin
            m  = exp_g1 ? 1 : 0;
            w  = (m == 1) ? m1_write      : m0_write;
            a  = (m == 1) ? m1_address    : m0_address;
            be = (m == 1) ? m1_byteenable : m0_byteenable;
            d  = (m == 1) ? m1_writedata  : m0_writedata;
            if (w) begin
                if (be[0]) ref_mem[a][7:0]  = d[7:0];
                if (be[1]) ref_mem[a][15:8] = d[15:8];
            end else begin
                rq.push_back('{m: m, data: ref_mem[a], due: cyc + 2});
            end
            prio = 1 - m;
        end
        cyc++;
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        model_eval();
        advance();
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_n    = 1'b0;
        m0_read    = 1'b1;
        m0_address = 8'h10;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            model_eval();
            n_vec++;
            if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
                n_err++;
                $display("FAIL reset_wait: m0=%b m1=%b required 1/1", m0_waitrequest, m1_waitrequest);
            end
            n_vec++;
            if (mem_chipselect !== 1'b0) begin
                n_err++;
                $display("FAIL reset_cs: got %b required 0", mem_chipselect);
            end
            n_vec++;
            if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_valid: m0=%b m1=%b required 0/0", m0_readdatavalid, m1_readdatavalid);
            end
            n_vec++;
            if (m0_readdata !== 16'h0000 || m1_readdata !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_rdata: m0=%h m1=%h required 0000/0000", m0_readdata, m1_readdata);
            end
            advance();
        end
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_single();
        idle();
        m0_write = 1'b1; m0_address = 8'h10; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
        #1;
        model_eval();
        n_vec++;
        if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_debugaccess !== 1'b1 ||
            mem_address !== 8'h10 || mem_writedata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL single_wr: wr=%b mw=%b dbg=%b a=%h d=%h required 0/1/1/10/BEEF",
                     m0_waitrequest, mem_write, mem_debugaccess, mem_address, mem_writedata);
        end
        advance();
        idle();
        m0_read = 1'b1; m0_address = 8'h10; m0_byteenable = 2'b00;
        #1;
        model_eval();
        n_vec++;
        if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 ||
            mem_byteenable !== 2'b11) begin
            n_err++;
            $display("FAIL single_rd: wr=%b cs=%b mw=%b be=%b required 0/1/0/11",
                     m0_waitrequest, mem_chipselect, mem_write, mem_byteenable);
        end
        advance();
        idle();
        for (int k = 1; k <= 3; k++) begin
            #1;
            model_eval();
            n_vec++;
            if (m0_readdatavalid !== (k == 2) || m1_readdatavalid !== 1'b0) begin
                n_err++;
                $display("FAIL single_rdv(+%0d): m0=%b m1=%b required %b/0",
                         k, m0_readdatavalid, m1_readdatavalid, (k == 2));
            end
            if (k >= 2) begin
                n_vec++;
                if (m0_readdata !== 16'hBEEF) begin
                    n_err++;
                    $display("FAIL single_rdata(+%0d): got %h required BEEF", k, m0_readdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_byte_lanes();
        idle();
        m0_write = 1'b1; m0_address = 8'h20; m0_writedata = 16'h1234; m0_byteenable = 2'b11;
        step();
        m0_writedata = 16'hAB00; m0_byteenable = 2'b10;
        #1;
        model_eval();
        n_vec++;
        if (mem_byteenable !== 2'b10 || mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL lane_wr: be=%b mw=%b required 10/1", mem_byteenable, mem_write);
        end
        advance();
        m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 2'b01;
        step();
        idle();
        step();
        #1;
        model_eval();
        n_vec++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== 16'hAB34) begin
            n_err++;
            $display("FAIL lane_rd: v=%b d=%h required 1/AB34", m0_readdatavalid, m0_readdata);
        end
        advance();
    endtask

    task automatic test_contention();
        int g0cnt = 0, g1cnt = 0, r0cnt = 0, r1cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            m0_write = 1'b1; m0_address = 8'h30 + 8'(i); m0_writedata = 16'hA000 + 16'(i); m0_byteenable = 2'b11;
            step();
            idle();
            m1_write = 1'b1; m1_address = 8'h40 + 8'(i); m1_writedata = 16'hB000 + 16'(i); m1_byteenable = 2'b11;
            step();
        end
        idle();
        m0_read = 1'b1; m0_address = 8'h30;
        m1_read = 1'b1; m1_address = 8'h40;
        for (int c = 0; c < 10; c++) begin
            logic g0, g1;
            if (c == 8) idle();
            #1;
            model_eval();
            n_vec++;
            if (m0_waitrequest !== !exp_g0 || m1_waitrequest !== !exp_g1) begin
                n_err++;
                $display("FAIL cont_grant(c%0d): wr0=%b wr1=%b required %b/%b",
                         c, m0_waitrequest, m1_waitrequest, !exp_g0, !exp_g1);
            end
            n_vec++;
            if (m0_readdatavalid !== exp_v0 || m1_readdatavalid !== exp_v1) begin
                n_err++;
                $display("FAIL cont_valid(c%0d): v0=%b v1=%b required %b/%b",
                         c, m0_readdatavalid, m1_readdatavalid, exp_v0, exp_v1);
            end
            if (m0_readdatavalid === 1'b1) begin
                n_vec++;
                if (m0_readdata !== 16'hA000 + 16'(r0cnt)) begin
                    n_err++;
                    $display("FAIL cont_m0_order: got %h required %h", m0_readdata, 16'hA000 + 16'(r0cnt));
                end
                r0cnt++;
            end
            if (m1_readdatavalid === 1'b1) begin
                n_vec++;
                if (m1_readdata !== 16'hB000 + 16'(r1cnt)) begin
                    n_err++;
                    $display("FAIL cont_m1_order: got %h required %h", m1_readdata, 16'hB000 + 16'(r1cnt));
                end
                r1cnt++;
            end
            if (m0_read && m0_waitrequest === 1'b0) g0cnt++;
            if (m1_read && m1_waitrequest === 1'b0) g1cnt++;
            g0 = exp_g0;
            g1 = exp_g1;
            advance();
            if (g0) m0_address++;
            if (g1) m1_address++;
        end
        n_vec++;
        if (g0cnt != 4 || g1cnt != 4 || r0cnt != 4 || r1cnt != 4) begin
            n_err++;
            $display("FAIL cont_counts: grants %0d/%0d responses %0d/%0d required 4/4 4/4",
                     g0cnt, g1cnt, r0cnt, r1cnt);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        m1_write = 1'b1; m1_address = 8'h00; m1_writedata = 16'h1357; m1_byteenable = 2'b11;
        step();
        m1_address = 8'hFF; m1_writedata = 16'h55AA;
        #1;
        model_eval();
        n_vec++;
        if (m1_waitrequest !== 1'b0 || mem_address !== 8'hFF) begin
            n_err++;
            $display("FAIL b2b_wr: wr=%b a=%h required 0/FF", m1_waitrequest, mem_address);
        end
        advance();
        m1_write = 1'b0; m1_read = 1'b1;
        step();
        m1_address = 8'h00;
        #1;
        model_eval();
        n_vec++;
        if (m1_waitrequest !== 1'b0 || mem_address !== 8'h00) begin
            n_err++;
            $display("FAIL b2b_rd: wr=%b a=%h required 0/00", m1_waitrequest, mem_address);
        end
        advance();
        idle();
        #1;
        model_eval();
        n_vec++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 16'h55AA || m0_readdatavalid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ff: v1=%b d=%h v0=%b required 1/55AA/0", m1_readdatavalid, m1_readdata, m0_readdatavalid);
        end
        advance();
        #1;
        model_eval();
        n_vec++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 16'h1357) begin
            n_err++;
            $display("FAIL b2b_wrap: v1=%b d=%h required 1/1357", m1_readdatavalid, m1_readdata);
        end
        advance();
        #1;
        model_eval();
        n_vec++;
        if (m1_readdatavalid !== 1'b0 || m1_readdata !== 16'h1357) begin
            n_err++;
            $display("FAIL b2b_hold: v1=%b d=%h required 0/1357", m1_readdatavalid, m1_readdata);
        end
        advance();
    endtask

    task automatic test_reset_midflight();
        idle();
        m0_read = 1'b1; m0_address = 8'h10;
        #1;
        model_eval();
        n_vec++;
        if (m0_waitrequest !== 1'b0) begin
            n_err++;
            $display("FAIL mid_accept: wr=%b required 0", m0_waitrequest);
        end
        advance();
        idle();
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            model_eval();
            n_vec++;
            if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_novalid(%0d): v0=%b v1=%b required 0/0", i, m0_readdatavalid, m1_readdatavalid);
            end
            advance();
            reset_n = 1'b1;
        end
        m0_read = 1'b1; m0_address = 8'h20;
        m1_read = 1'b1; m1_address = 8'h21;
        #1;
        model_eval();
        n_vec++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            n_err++;
            $display("FAIL mid_prio: wr0=%b wr1=%b required 0/1", m0_waitrequest, m1_waitrequest);
        end
        advance();
        idle();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_random();
        int sel;
        for (int c = 0; c < 304; c++) begin
            logic g0, g1, exp_mw;
            if (c < 300) begin
                if (!m0_read && !m0_write) begin
                    sel = $urandom_range(0, 3);
                    m0_read       = (sel == 1 || sel == 3);
                    m0_write      = (sel >= 2);
                    m0_address    = 8'hE0 | 8'($urandom_range(0, 15));
                    m0_byteenable = 2'($urandom_range(0, 3));
                    m0_writedata  = 16'($urandom);
                end
                if (!m1_read && !m1_write) begin
                    sel = $urandom_range(0, 3);
                    m1_read       = (sel == 1 || sel == 3);
                    m1_write      = (sel >= 2);
                    m1_address    = 8'hE0 | 8'($urandom_range(0, 15));
                    m1_byteenable = 2'($urandom_range(0, 3));
                    m1_writedata  = 16'($urandom);
                end
            end
            #1;
            model_eval();
            exp_mw = exp_g0 ? m0_write : (exp_g1 ? m1_write : 1'b0);
            n_vec++;
            if (m0_waitrequest !== !exp_g0 || m1_waitrequest !== !exp_g1 ||
                mem_chipselect !== (exp_g0 | exp_g1) || mem_write !== exp_mw) begin
                n_err++;
                $display("FAIL rnd_grant(c%0d): wr0=%b wr1=%b cs=%b mw=%b required %b/%b/%b/%b",
                         c, m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write,
                         !exp_g0, !exp_g1, exp_g0 | exp_g1, exp_mw);
            end
            n_vec++;
            if (m0_readdatavalid !== exp_v0 || m1_readdatavalid !== exp_v1) begin
                n_err++;
                $display("FAIL rnd_valid(c%0d): v0=%b v1=%b required %b/%b",
                         c, m0_readdatavalid, m1_readdatavalid, exp_v0, exp_v1);
            end
            n_vec++;
            if (m0_readdata !== exp_d0 || m1_readdata !== exp_d1) begin
                n_err++;
                $display("FAIL rnd_rdata(c%0d): d0=%h d1=%h required %h/%h",
                         c, m0_readdata, m1_readdata, exp_d0, exp_d1);
            end
            g0 = exp_g0;
            g1 = exp_g1;
            advance();
            if (g0) begin m0_read = 1'b0; m0_write = 1'b0; end
            if (g1) begin m1_read = 1'b0; m1_write = 1'b0; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
        cyc = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_byte_lanes();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
